// File: rtl/regbank_param.sv
// regbank_param
//   Parametrised register bank with two combinational read ports and one
//   write port. An optional hardwired zero register makes register 0 read as
//   zero and ignore writes. A sequential clear engine sweeps the whole array
//   to zero on request and reports progress with a busy/done handshake.
//
//   Optional feature (macro REGBANK_BYPASS_EN):
//     When defined, a same-cycle write is forwarded to any read port that
//     addresses the written register. When undefined, reads always return
//     the stored contents.
//
// Parameters:
//   DATA_W   - register width
//   ADDR_W   - address width, depth is 2**ADDR_W
//   ZERO_REG - 1: register 0 is hardwired to zero, 0: ordinary register
//
// Ports:
//   ck         in   clock, rising edge
//   reset_bank in   asynchronous active-low reset
//   A1, A2     in   read addresses
//   A3         in   write address
//   WD3        in   write data
//   WE3        in   write enable (ignored while busy)
//   clr_req    in   start a clear sweep (honoured in IDLE only)
//   RD1, RD2   out  read data (forced to zero while busy or in reset)
//   busy       out  registered, high during the sweep
//   clr_done   out  registered, one-cycle pulse when the sweep completes
module regbank_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              ck,
  input  logic              reset_bank,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  input  logic              clr_req,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_n;
  logic              sweep_en;
  logic              wr_en;
  logic [DATA_W-1:0] mem [DEPTH];

  // A write lands only outside the sweep, and never into a hardwired
  // register 0.
  assign wr_en = WE3 && !busy && !((ZERO_REG != 0) && (A3 == '0));

  // State register plus the registered busy/clr_done outputs. The outputs
  // are derived from the next state so they line up with the state itself
  // while remaining free of combinational glitches.
  always_ff @(posedge ck or negedge reset_bank) begin
    if (!reset_bank) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      busy     <= (state_n == CLEAR);
      clr_done <= (state_n == DONE);
    end
  end

  // Next-state logic for the clear engine. The sweep stops on the terminal
  // count rather than on wrap, so the counter is parked at zero instead of
  // overflowing on the last register.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sweep_en = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      CLEAR: begin
        sweep_en = 1'b1;
        if (cnt == {ADDR_W{1'b1}}) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Register array. The sweep and the write port never act in the same
  // cycle because writes are blocked while busy.
  always_ff @(posedge ck or negedge reset_bank) begin
    if (!reset_bank) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (sweep_en) begin
        mem[cnt] <= '0;
      end else if (wr_en) begin
        mem[A3] <= WD3;
      end
    end
  end

  // Read port 1. The forced-zero rule is applied last so it overrides both
  // the stored value and any forwarded write data.
  always_comb begin
    RD1 = mem[A1];
    if ((ZERO_REG != 0) && (A1 == '0)) begin
      RD1 = '0;
    end
`ifdef REGBANK_BYPASS_EN
    if (wr_en && (A1 == A3)) begin
      RD1 = WD3;
    end
`endif
    if (busy || !reset_bank) begin
      RD1 = '0;
    end
  end

  // Read port 2, identical in behaviour to port 1.
  always_comb begin
    RD2 = mem[A2];
    if ((ZERO_REG != 0) && (A2 == '0)) begin
      RD2 = '0;
    end
`ifdef REGBANK_BYPASS_EN
    if (wr_en && (A2 == A3)) begin
      RD2 = WD3;
    end
`endif
    if (busy || !reset_bank) begin
      RD2 = '0;
    end
  end

endmodule

// File: tb/tb_regbank_param.sv
// tb_regbank_param
//   Testbench for regbank_param. Two instances share one stimulus stream:
//   one with a hardwired zero register and one without. A reference model
//   holds the register contents as plain arrays and treats a clear sweep as
//   a countdown of busy cycles after which the whole array becomes zero.
module tb_regbank_param;

  localparam int DEPTH = 32;

  logic        ck = 1'b0;
  logic        reset_bank;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD3;
  logic        WE3, clr_req;
  logic [31:0] rd1_z, rd2_z, rd1_n, rd2_n;
  logic        busy_z, done_z, busy_n, done_n;

  logic [31:0] mem_z [DEPTH];
  logic [31:0] mem_n [DEPTH];
  int          sweep_left;
  bit          done_pend;
  int          n_compared = 0;
  int          n_mismatched = 0;
  int          n_busy, n_done;

  always #5 ck = ~ck;

  regbank_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_z (
    .ck(ck), .reset_bank(reset_bank), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
    .WE3(WE3), .clr_req(clr_req), .RD1(rd1_z), .RD2(rd2_z), .busy(busy_z),
    .clr_done(done_z)
  );

  regbank_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_n (
    .ck(ck), .reset_bank(reset_bank), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
    .WE3(WE3), .clr_req(clr_req), .RD1(rd1_n), .RD2(rd2_n), .busy(busy_n),
    .clr_done(done_n)
  );

  // Single comparison point: counts, asserts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                               input logic clr, input logic [4:0] a1, input logic [4:0] a2);
    WE3     = we;
    A3      = a3;
    WD3     = wd;
    clr_req = clr;
    A1      = a1;
    A2      = a2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mem_z[i] = 32'd0;
      mem_n[i] = 32'd0;
    end
    sweep_left = 0;
    done_pend  = 1'b0;
  endtask

  // Expected combinational read value for the current inputs.
  function automatic logic [31:0] model_read(input bit zr, input logic [4:0] a);
    logic [31:0] v;
    if (!reset_bank || sweep_left > 0) return 32'd0;
    if (zr) v = (a == 5'd0) ? 32'd0 : mem_z[a];
    else    v = mem_n[a];
`ifdef REGBANK_BYPASS_EN
    if (WE3 && (a == A3) && !(zr && A3 == 5'd0)) v = WD3;
`endif
    return v;
  endfunction

  // Compare every output of both instances against the model.
  task automatic check_all(input string tag);
    logic [31:0] exp_busy, exp_done;
    #1;
    exp_busy = (sweep_left > 0) ? 32'd1 : 32'd0;
    exp_done = done_pend ? 32'd1 : 32'd0;
    checkOutput({tag, ".rd1_z"}, rd1_z, model_read(1'b1, A1));
    checkOutput({tag, ".rd2_z"}, rd2_z, model_read(1'b1, A2));
    checkOutput({tag, ".rd1_n"}, rd1_n, model_read(1'b0, A1));
    checkOutput({tag, ".rd2_n"}, rd2_n, model_read(1'b0, A2));
    checkOutput({tag, ".busy_z"}, {31'd0, busy_z}, exp_busy);
    checkOutput({tag, ".busy_n"}, {31'd0, busy_n}, exp_busy);
    checkOutput({tag, ".done_z"}, {31'd0, done_z}, exp_done);
    checkOutput({tag, ".done_n"}, {31'd0, done_n}, exp_done);
  endtask

  // Advance one clock edge and update the model from the applied inputs.
  task automatic tick();
    @(posedge ck);
    if (reset_bank) begin
      if (sweep_left > 0) begin
        sweep_left--;
        if (sweep_left == 0) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_z[i] = 32'd0;
            mem_n[i] = 32'd0;
          end
          done_pend = 1'b1;
        end
      end else begin
        if (WE3) begin
          if (A3 != 5'd0) mem_z[A3] = WD3;
          mem_n[A3] = WD3;
        end
        if (done_pend) done_pend = 1'b0;
        else if (clr_req) sweep_left = DEPTH;
      end
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held, then released.
    reset_bank = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd31);
    model_reset();
    check_all("reset_held");
    repeat (2) @(posedge ck);
    #1;
    reset_bank = 1'b1;
    check_all("reset_rel");
    checkOutput("reset_rd1", rd1_z, 32'd0);

    // Directed writes and reads, including register 0.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    check_all("wr5");
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd5);
    check_all("rd5");
    checkOutput("rd5_const", rd1_z, 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd1, 5'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    check_all("rd0");
    checkOutput("rd0_zr", rd2_z, 32'd0);
    checkOutput("rd0_nz", rd2_n, 32'h1234);

    // Randomised traffic with occasional clear requests.
    for (int k = 0; k < 80; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                    ($urandom_range(0, 39) == 0), 5'($urandom), 5'($urandom));
      check_all("rand");
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    for (int k = 0; k < 80 && (sweep_left > 0 || done_pend); k++) begin
      check_all("drain");
      tick();
    end
    checkOutput("drain_idle", {31'd0, busy_z}, 32'd0);

    // Fill 1..31 with their index, then sweep with a blocked write and a
    // second request part way through.
    for (int i = 1; i < DEPTH; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i), 1'b0, 5'($urandom), 5'($urandom));
      check_all("fill");
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd31);
    check_all("sweep_req");
    tick();
    n_busy = 0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(c == 3, 5'd9, 32'hAA, c == 5, 5'($urandom), 5'($urandom));
      check_all("sweep");
      if (busy_z) n_busy++;
      if (done_z) n_done++;
      tick();
    end
    checkOutput("busy_len", n_busy, 32'd32);
    checkOutput("done_len", n_done, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'(i), 5'(i));
      check_all("post_clr");
      checkOutput("post_clr_n", rd1_n, 32'd0);
      tick();
    end

    // Same-cycle write/read of register 12.
    applyStimulus(1'b1, 5'd12, 32'h77, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd12, 32'h55, 1'b0, 5'd12, 5'd12);
    check_all("byp");
`ifdef REGBANK_BYPASS_EN
    checkOutput("byp_same", rd1_z, 32'h55);
`else
    checkOutput("byp_same", rd1_z, 32'h77);
`endif
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd12, 5'd12);
    check_all("byp_next");
    checkOutput("byp_next_c", rd1_z, 32'h55);

    // Reset in the middle of a sweep.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd5);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd12, 5'd5);
    for (int c = 0; c < 10; c++) begin
      check_all("pre_rst");
      tick();
    end
    reset_bank = 1'b0;
    model_reset();
    check_all("mid_rst");
    checkOutput("mid_rst_busy", {31'd0, busy_z}, 32'd0);
    @(posedge ck);
    #1;
    reset_bank = 1'b1;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'($urandom), 5'($urandom));
      check_all("after_rst");
      tick();
    end
    applyStimulus(1'b1, 5'd3, 32'hCAFE, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd12);
    check_all("fresh_rd");
    checkOutput("fresh_rd_c", rd1_z, 32'hCAFE);
    checkOutput("fresh_rd12", rd2_n, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
